// File: rtl/cmp_red_seq_pkg.sv
// Shared types, opcode constants and helpers for the min/max reduction sequencer.
package cmp_red_seq_pkg;

   // Low bit of the 7-bit ocode: integer (0) versus floating-point (1) datapath.
   localparam logic INT = 1'b0;

   // funct6 encodings; the vector-vector and reduction forms share one code.
   localparam logic [5:0] F6_VMINU_VREDMINU  = 6'b000100;
   localparam logic [5:0] F6_VMIN_VREDMIN    = 6'b000101;
   localparam logic [5:0] F6_VMAXU_VREDMAXU  = 6'b000110;
   localparam logic [5:0] F6_VMAX_VREDMAX    = 6'b000111;
   localparam logic [5:0] F6_VMSEQ_VMANDNOT  = 6'b011000;

   localparam logic [6:0] OC_VREDMINU = {F6_VMINU_VREDMINU, INT};
   localparam logic [6:0] OC_VREDMIN  = {F6_VMIN_VREDMIN, INT};
   localparam logic [6:0] OC_VREDMAXU = {F6_VMAXU_VREDMAXU, INT};
   localparam logic [6:0] OC_VREDMAX  = {F6_VMAX_VREDMAX, INT};
   localparam logic [6:0] OC_VMSEQ    = {F6_VMSEQ_VMANDNOT, INT};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } red_state_t;

   // Observation struct: sequencer state and whether the comparator last picked the element.
   typedef struct packed {
      red_state_t state;
      logic       took_b;
   } red_dbg_t;

   // True only for the four integer min/max reductions the sequencer can run.
   function automatic logic is_red_op(input logic [6:0] ocode);
      return (ocode == OC_VREDMIN)  || (ocode == OC_VREDMINU) ||
             (ocode == OC_VREDMAX)  || (ocode == OC_VREDMAXU);
   endfunction

endpackage

// File: rtl/cmp_red_seq_if.sv
// Issue/lane-side bundle for the reduction sequencer.
// Element stream: a beat transfers on a rising clock edge where elem_valid_i and
// elem_ready_o are both high; the source holds data/mask stable while valid is high
// and not yet accepted, and the sink may hold ready low for any number of cycles.
interface cmp_red_seq_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 7
);
   logic                  start_i;
   logic [6:0]            ocode_i;
   logic [CNT_W-1:0]      vl_i;
   logic [DATA_WIDTH-1:0] init_i;
   logic                  elem_valid_i;
   logic                  elem_ready_o;
   logic [DATA_WIDTH-1:0] elem_data_i;
   logic                  elem_mask_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;
   logic [DATA_WIDTH-1:0] result_o;

   modport master (
      output start_i, ocode_i, vl_i, init_i, elem_valid_i, elem_data_i, elem_mask_i,
      input  elem_ready_o, busy_o, done_o, err_o, result_o
   );

   modport slave (
      input  start_i, ocode_i, vl_i, init_i, elem_valid_i, elem_data_i, elem_mask_i,
      output elem_ready_o, busy_o, done_o, err_o, result_o
   );
endinterface

// File: rtl/cmp_red_seq_com.sv
// COM: integer min/max comparator. Result is combinational so the caller can fold it
// into an accumulator in the same cycle; a registered flag records the last choice.
module cmp_red_seq_com
   import cmp_red_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  module_clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [6:0]            ocode_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  took_b_o
);
   logic is_max;
   logic is_signed;
   logic op_ok;
   logic b_lt_a;
   logic b_gt_a;
   logic take_b;

   // Decode the operation and pick a or b; a passes through when disabled or unknown.
   always_comb begin
      is_max    = 1'b0;
      is_signed = 1'b0;
      op_ok     = 1'b1;
      case (ocode_i)
         OC_VREDMIN:  is_signed = 1'b1;
         OC_VREDMINU: is_signed = 1'b0;
         OC_VREDMAX:  begin is_max = 1'b1; is_signed = 1'b1; end
         OC_VREDMAXU: is_max = 1'b1;
         default:     op_ok = 1'b0;
      endcase
      if (is_signed) begin
         b_lt_a = $signed(b_i) < $signed(a_i);
         b_gt_a = $signed(b_i) > $signed(a_i);
      end else begin
         b_lt_a = b_i < a_i;
         b_gt_a = b_i > a_i;
      end
      take_b   = en_i & op_ok & (is_max ? b_gt_a : b_lt_a);
      result_o = take_b ? b_i : a_i;
   end

   // Remember whether the most recent enabled compare selected the b operand.
   always_ff @(posedge module_clk_i or posedge rst_i) begin
      if (rst_i) begin
         took_b_o <= 1'b0;
      end else if (en_i) begin
         took_b_o <= take_b;
      end
   end
endmodule

// File: rtl/cmp_red_seq.sv
// Min/max reduction sequencer: seeds an accumulator with vs1[0], folds one vs2 element
// per accepted beat through COM, and returns the scalar with a one-cycle done pulse.
module cmp_red_seq
   import cmp_red_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_VL     = 64,
   parameter int CNT_W      = $clog2(MAX_VL + 1)
) (
   input  logic         module_clk_i,
   input  logic         rst_i,
   cmp_red_seq_if.slave bus,
   output red_dbg_t     dbg_o
);
   red_state_t            state;
   logic [6:0]            ocode_q;
   logic [CNT_W-1:0]      vl_q;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      vl_clamped;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [DATA_WIDTH-1:0] com_result;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic                  ready_q;
   logic                  hs;
   logic                  com_en;
   logic                  com_took_b;

   // Requests above MAX_VL run exactly MAX_VL elements.
   assign vl_clamped = (bus.vl_i > CNT_W'(MAX_VL)) ? CNT_W'(MAX_VL) : bus.vl_i;
   assign hs         = bus.elem_valid_i & ready_q;
   assign com_en     = (state == RUN);
   // Masked-off elements are consumed but leave the accumulator untouched.
   assign acc_next   = bus.elem_mask_i ? com_result : acc;

   cmp_red_seq_com #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_com (
      .module_clk_i (module_clk_i),
      .rst_i        (rst_i),
      .en_i         (com_en),
      .a_i          (acc),
      .b_i          (bus.elem_data_i),
      .ocode_i      (ocode_q),
      .result_o     (com_result),
      .took_b_o     (com_took_b)
   );

   // Sequencer FSM with all visible outputs registered alongside the state.
   always_ff @(posedge module_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         ocode_q  <= '0;
         vl_q     <= '0;
         cnt      <= '0;
         acc      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  ocode_q <= bus.ocode_i;
                  vl_q    <= vl_clamped;
                  acc     <= bus.init_i;
                  cnt     <= '0;
                  if (!is_red_op(bus.ocode_i)) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     err_q    <= 1'b1;
                     result_q <= bus.init_i;
                  end else if (vl_clamped == '0) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= bus.init_i;
                  end else begin
                     state   <= RUN;
                     busy_q  <= 1'b1;
                     ready_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  acc <= acc_next;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == vl_q - CNT_W'(1)) begin
                     state    <= DONE;
                     busy_q   <= 1'b0;
                     ready_q  <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= acc_next;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.err_o        = err_q;
   assign bus.elem_ready_o = ready_q;
   assign bus.result_o     = result_q;
   assign dbg_o.state      = state;
   assign dbg_o.took_b     = com_took_b;
endmodule
